axi_rd_ram_bridge: RTL and testbench

AXI4 read-slave that converts read bursts from the DMA's MM2S master into single-beat requests on the 1-cycle-latency RAM read port (`ren`/`addr`/`data`) that backs simulation memory. It sits directly upstream of the memory model: AR/R on one side, word-addressed RAM read on the other. It sustains one beat per cycle, absorbs R-channel backpressure without losing RAM data, and lets a new burst overlap the tail of the previous one.

---
 rtl/axi_rd_bridge_pkg.sv | 43 ++++
 rtl/axi_rd_skid_fifo.sv | 51 +++++
 rtl/axi_rd_ram_bridge.sv | 179 +++++++++++++++++
 tb/tb_axi_rd_ram_bridge.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_bridge_pkg.sv
// Shared types and helpers for the AXI4 read to RAM bridge.
// Holds the burst encoding, response codes, FSM state constants, the
// width-independent part of the per-beat metadata and the address stepper.
package axi_rd_bridge_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Per-beat tag; the top wraps it together with an ID of its own width.
  typedef struct packed {
    logic       last;
    logic [1:0] resp;
  } beat_tag_t;

  // Byte address of the beat following addr. WRAP stays inside the aligned
  // ((len+1) << size)-byte window; legality is decided by the caller.
  function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                            input logic [2:0]  size,
                                            input logic [7:0]  len,
                                            input logic [1:0]  burst);
    logic [63:0] step;
    logic [63:0] incr;
    logic [63:0] mask;
    step = 64'd1 << size;
    incr = addr + step;
    mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
      default:     next_addr = incr;
    endcase
  endfunction

endpackage

// File: rtl/axi_rd_skid_fifo.sv
// Two-entry FIFO holding returned beats ahead of the R channel.
// Push and pop in the same cycle leave the occupancy unchanged. Storage is
// cleared on reset so the R outputs read as zero while the FIFO is empty
// after reset.
module axi_rd_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/axi_rd_ram_bridge.sv
// AXI4 read slave that turns AR bursts into single-beat reads on a
// 1-cycle-latency word-addressed RAM port.
// Optional feature macro: AXI_RD_BRIDGE_WRAP_EN makes WRAP bursts of 2, 4,
// 8 or 16 beats legal; without it every WRAP burst returns SLVERR beats.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and once the bridge raises rvalid
// the R payload stays stable until rready is seen.
module axi_rd_ram_bridge
  import axi_rd_bridge_pkg::*;
#(
  parameter int AXI_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int LSB            = $clog2(AXI_WIDTH) - 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXI_ID_WIDTH-1:0]       s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]       s_axi_rid,
  output logic [AXI_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic                          ram_ren,
  output logic [AXI_ADDR_WIDTH-LSB-1:0] ram_addr,
  input  logic [AXI_WIDTH-1:0]          ram_data,
  output logic [0:0]                    dbg_state
);

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    beat_tag_t               tag;
  } beat_meta_t;

  localparam int         META_W   = $bits(beat_meta_t);
  localparam int         FIFO_W   = META_W + AXI_WIDTH;
  localparam logic [2:0] MAX_SIZE = 3'(LSB);

  logic [0:0]                state_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [7:0]                len_q;
  logic [7:0]                cnt_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic                      illegal_q;

  logic                      infl_q;
  beat_meta_t                infl_meta_q;

  logic                      ar_hs;
  logic                      ar_illegal;
  logic                      wrap_ok;
  logic                      pop;
  logic                      credit;
  logic                      issue;
  logic                      last_beat;

  logic [1:0]                fifo_count;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [FIFO_W-1:0]         fifo_din;
  logic [FIFO_W-1:0]         fifo_dout;
  beat_meta_t                out_meta;

  assign s_axi_arready = (state_q == ST_IDLE) && !rst;
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  assign dbg_state     = state_q;

  // Classify the burst on the AR channel as legal or SLVERR-only.
  always_comb begin
    wrap_ok = 1'b0;
`ifdef AXI_RD_BRIDGE_WRAP_EN
    wrap_ok = (s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3) ||
              (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15);
`endif
    ar_illegal = (s_axi_arsize > MAX_SIZE) ||
                 ((s_axi_arburst == BURST_WRAP) && !wrap_ok);
  end

  // A beat may issue only if it is guaranteed a FIFO slot when its data
  // returns: FIFO occupancy after this cycle's pop plus the in-flight beat
  // must stay below two.
  assign pop       = s_axi_rvalid && s_axi_rready;
  assign credit    = infl_q ? ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))
                            : (!fifo_full || pop);
  assign issue     = (state_q == ST_BURST) && credit;
  assign last_beat = (cnt_q == len_q);
  assign ram_ren   = issue && !illegal_q;
  assign ram_addr  = addr_q[AXI_ADDR_WIDTH-1:LSB];

  // Burst FSM: accept AR in IDLE, issue one beat per credit in BURST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      id_q      <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ar_hs) begin
            addr_q    <= s_axi_araddr;
            id_q      <= s_axi_arid;
            len_q     <= s_axi_arlen;
            size_q    <= s_axi_arsize;
            burst_q   <= s_axi_arburst;
            illegal_q <= ar_illegal;
            cnt_q     <= 8'd0;
            state_q   <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (issue) begin
            addr_q <= AXI_ADDR_WIDTH'(next_addr(64'(addr_q), size_q, len_q, burst_q));
            cnt_q  <= cnt_q + 8'd1;
            if (last_beat) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Metadata of the beat whose RAM data arrives next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_q      <= 1'b0;
      infl_meta_q <= '0;
    end else begin
      infl_q <= issue;
      if (issue) begin
        infl_meta_q.id       <= id_q;
        infl_meta_q.tag.last <= last_beat;
        infl_meta_q.tag.resp <= illegal_q ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Error beats never read the RAM, so their data is forced to zero.
  assign fifo_din = {infl_meta_q,
                     (infl_meta_q.tag.resp == RESP_SLVERR) ? {AXI_WIDTH{1'b0}} : ram_data};

  axi_rd_skid_fifo #(
    .W(FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (infl_q),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_meta     = fifo_dout[FIFO_W-1:AXI_WIDTH];
  assign s_axi_rvalid = !fifo_empty;
  assign s_axi_rid    = out_meta.id;
  assign s_axi_rlast  = out_meta.tag.last;
  assign s_axi_rresp  = out_meta.tag.resp;
  assign s_axi_rdata  = fifo_dout[AXI_WIDTH-1:0];

endmodule

// File: tb/tb_axi_rd_ram_bridge.sv
// Self-checking bench for axi_rd_ram_bridge (AXI_WIDTH=128, LSB=4).
// Table of directed bursts plus hand-written backpressure, back-to-back and
// mid-burst reset sequences. WRAP expectations follow AXI_RD_BRIDGE_WRAP_EN.
module tb_axi_rd_ram_bridge;

  localparam int AW  = 128;
  localparam int ADW = 32;
  localparam int IDW = 6;
  localparam int WAW = 28;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic [IDW-1:0] s_axi_arid = '0;
  logic [ADW-1:0] s_axi_araddr = '0;
  logic [7:0]     s_axi_arlen = '0;
  logic [2:0]     s_axi_arsize = '0;
  logic [1:0]     s_axi_arburst = '0;
  logic           s_axi_arvalid = 1'b0;
  logic           s_axi_arready;
  logic [IDW-1:0] s_axi_rid;
  logic [AW-1:0]  s_axi_rdata;
  logic [1:0]     s_axi_rresp;
  logic           s_axi_rlast;
  logic           s_axi_rvalid;
  logic           s_axi_rready = 1'b0;
  logic           ram_ren;
  logic [WAW-1:0] ram_addr;
  logic [AW-1:0]  ram_data = '0;
  logic [0:0]     dbg_state;

  axi_rd_ram_bridge #(
    .AXI_WIDTH      (AW),
    .AXI_ADDR_WIDTH (ADW),
    .AXI_ID_WIDTH   (IDW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_arid    (s_axi_arid),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .ram_ren       (ram_ren),
    .ram_addr      (ram_addr),
    .ram_data      (ram_data),
    .dbg_state     (dbg_state)
  );

  // RAM contents are a pure function of the word address.
  function automatic logic [AW-1:0] ram_word(input logic [WAW-1:0] a);
    return {4{4'hD, a}};
  endfunction

  always @(posedge clk) begin
    if (ram_ren) ram_data <= ram_word(ram_addr);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int fails  = 0;

  logic [136:0]   exp_q[$];
  logic [WAW-1:0] exp_addr_q[$];
  int             ren_cyc_q[$];
  int             beat_cyc_q[$];

  logic         occ_en = 1'b0;
  int           out_cnt = 0;
  int           stall_cnt = 0;
  logic         hold_prev = 1'b0;
  logic [137:0] prev_r = '0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge what the next rising edge commits.
  always @(negedge clk) begin
    logic [WAW-1:0] ea;
    logic [136:0]   eb;
    logic [137:0]   cur;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (ram_ren) begin
        ren_cyc_q.push_back(cyc);
        if (exp_addr_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL ram_ren_unexpected: read of word %0h, required no read", ram_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          chk("ram_addr", 160'(ram_addr), 160'(ea));
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        beat_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL r_beat_unexpected: rid %0h rdata %0h, required no beat", s_axi_rid, s_axi_rdata);
        end else begin
          eb = exp_q.pop_front();
          chk("r_beat", 160'({s_axi_rid, s_axi_rlast, s_axi_rresp, s_axi_rdata}), 160'(eb));
        end
      end
      if (occ_en) begin
        out_cnt = out_cnt + (ram_ren ? 1 : 0) - ((s_axi_rvalid && s_axi_rready) ? 1 : 0);
        if (ram_ren) chk("credit_le2", 160'(out_cnt <= 2), 160'(1));
      end
      if (s_axi_rvalid && !s_axi_rready) stall_cnt++;
      cur = {s_axi_rvalid, s_axi_rid, s_axi_rlast, s_axi_rresp, s_axi_rdata};
      if (hold_prev) chk("r_hold", 160'(cur), 160'(prev_r));
      hold_prev = s_axi_rvalid && !s_axi_rready;
      prev_r = cur;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the AR handshake.
  task automatic send_ar(input logic [IDW-1:0] id, input logic [ADW-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, output int hs);
    bit ok;
    ok = 1'b0;
    s_axi_arid    = id;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arsize  = size;
    s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (s_axi_arready) begin
        ok = 1'b1;
        break;
      end
    end
    hs = cyc;
    chk("ar_accept", 160'(ok), 160'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input logic [IDW-1:0] id, input logic [7:0] len,
                            input logic slverr, input logic [7:0][WAW-1:0] wa);
    for (int b = 0; b <= int'(len); b++) begin
      if (!slverr) exp_addr_q.push_back(wa[b]);
      exp_q.push_back({id, (b == int'(len)), (slverr ? 2'd2 : 2'd0),
                       (slverr ? {AW{1'b0}} : ram_word(wa[b]))});
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && exp_addr_q.size() == 0) break;
      @(posedge clk);
    end
    chk({name, "_drain"}, 160'(exp_q.size() + exp_addr_q.size()), 160'(0));
    exp_q.delete();
    exp_addr_q.delete();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [IDW-1:0]       id;
    logic [ADW-1:0]       addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 slverr;
    logic [7:0][WAW-1:0]  waddr;   // element 0 is the first beat
  } vec_t;

  vec_t vt[6];

  task automatic run_vec(input int i);
    int   hs;
    vec_t v;
    v = vt[i];
    ren_cyc_q.delete();
    beat_cyc_q.delete();
    push_beats(v.id, v.len, v.slverr, v.waddr);
    send_ar(v.id, v.addr, v.len, v.size, v.burst, hs);
    s_axi_arvalid = 1'b0;
    wait_drain($sformatf("vec%0d", i));
    chk($sformatf("vec%0d_ren_count", i), 160'(ren_cyc_q.size()),
        160'(v.slverr ? 0 : int'(v.len) + 1));
    chk($sformatf("vec%0d_beat_count", i), 160'(beat_cyc_q.size()), 160'(int'(v.len) + 1));
    if (ren_cyc_q.size() > 0)
      chk($sformatf("vec%0d_ren_latency", i), 160'(ren_cyc_q[0] - hs), 160'(1));
    if (beat_cyc_q.size() > 0) begin
      chk($sformatf("vec%0d_r_latency", i), 160'(beat_cyc_q[0] - hs), 160'(3));
      chk($sformatf("vec%0d_no_bubble", i),
          160'(beat_cyc_q[beat_cyc_q.size()-1] - beat_cyc_q[0]), 160'(int'(v.len)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int hs1;
    int hs2;

    vt[0] = '{6'd5,  32'h0000_0100, 8'd3, 3'd4, 2'd1, 1'b0,
              {28'h0, 28'h0, 28'h0, 28'h0, 28'h13, 28'h12, 28'h11, 28'h10}};
    vt[1] = '{6'd9,  32'h0000_0004, 8'd5, 3'd2, 2'd1, 1'b0,
              {28'h0, 28'h0, 28'h1, 28'h1, 28'h1, 28'h0, 28'h0, 28'h0}};
    vt[2] = '{6'h2A, 32'h0000_0230, 8'd2, 3'd4, 2'd0, 1'b0,
              {28'h0, 28'h0, 28'h0, 28'h0, 28'h0, 28'h23, 28'h23, 28'h23}};
    vt[3] = '{6'h3F, 32'h0000_0000, 8'd2, 3'd5, 2'd1, 1'b1,
              {28'h0, 28'h0, 28'h0, 28'h0, 28'h0, 28'h0, 28'h0, 28'h0}};
`ifdef AXI_RD_BRIDGE_WRAP_EN
    vt[4] = '{6'd7,  32'h0000_0030, 8'd3, 3'd4, 2'd2, 1'b0,
              {28'h0, 28'h0, 28'h0, 28'h0, 28'h2, 28'h1, 28'h0, 28'h3}};
`else
    vt[4] = '{6'd7,  32'h0000_0030, 8'd3, 3'd4, 2'd2, 1'b1,
              {28'h0, 28'h0, 28'h0, 28'h0, 28'h0, 28'h0, 28'h0, 28'h0}};
`endif
    vt[5] = '{6'd0,  32'hFFFF_FFF0, 8'd0, 3'd4, 2'd1, 1'b0,
              {28'h0, 28'h0, 28'h0, 28'h0, 28'h0, 28'h0, 28'h0, 28'hFFFFFFF}};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", 160'(s_axi_arready), 160'(0));
    chk("rst_ram_ren", 160'(ram_ren), 160'(0));
    chk("rst_ram_addr", 160'(ram_addr), 160'(0));
    chk("rst_rvalid", 160'(s_axi_rvalid), 160'(0));
    chk("rst_rlast", 160'(s_axi_rlast), 160'(0));
    chk("rst_rresp", 160'(s_axi_rresp), 160'(0));
    chk("rst_rid", 160'(s_axi_rid), 160'(0));
    chk("rst_rdata", 160'(s_axi_rdata), 160'(0));
    chk("rst_state", 160'(dbg_state), 160'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arready_after_release", 160'(s_axi_arready), 160'(1));
    s_axi_rready = 1'b1;

    // Table-driven bursts with rready held high
    for (int i = 0; i < 6; i++) run_vec(i);

    // Backpressure: rready toggles every cycle
    ren_cyc_q.delete();
    beat_cyc_q.delete();
    stall_cnt = 0;
    push_beats(6'h11, 8'd7, 1'b0,
               {28'h47, 28'h46, 28'h45, 28'h44, 28'h43, 28'h42, 28'h41, 28'h40});
    out_cnt = 0;
    occ_en  = 1'b1;
    send_ar(6'h11, 32'h0000_0400, 8'd7, 3'd4, 2'd1, hs1);
    s_axi_arvalid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && exp_addr_q.size() == 0) break;
      @(posedge clk);
      #1;
      s_axi_rready = ~s_axi_rready;
    end
    occ_en = 1'b0;
    s_axi_rready = 1'b1;
    wait_drain("backpressure");
    chk("bp_beat_count", 160'(beat_cyc_q.size()), 160'(8));
    chk("bp_stalls_seen", 160'(stall_cnt > 0), 160'(1));

    // Back-to-back bursts with arvalid held across them
    ren_cyc_q.delete();
    beat_cyc_q.delete();
    push_beats(6'd1, 8'd1, 1'b0, {28'h0, 28'h0, 28'h0, 28'h0, 28'h0, 28'h0, 28'h51, 28'h50});
    push_beats(6'd2, 8'd0, 1'b0, {28'h0, 28'h0, 28'h0, 28'h0, 28'h0, 28'h0, 28'h0, 28'h60});
    send_ar(6'd1, 32'h0000_0500, 8'd1, 3'd4, 2'd1, hs1);
    send_ar(6'd2, 32'h0000_0600, 8'd0, 3'd4, 2'd1, hs2);
    s_axi_arvalid = 1'b0;
    wait_drain("b2b");
    chk("b2b_ren_count", 160'(ren_cyc_q.size()), 160'(3));
    chk("b2b_beat_count", 160'(beat_cyc_q.size()), 160'(3));
    if (ren_cyc_q.size() == 3)
      chk("b2b_ren_gap_ge2", 160'((ren_cyc_q[2] - ren_cyc_q[1]) >= 2), 160'(1));
    if (beat_cyc_q.size() == 3)
      chk("b2b_first_pair_adjacent", 160'(beat_cyc_q[1] - beat_cyc_q[0]), 160'(1));

    // Reset asserted while the 3rd beat of an 8-beat burst is presented
    push_beats(6'd3, 8'd7, 1'b0,
               {28'h87, 28'h86, 28'h85, 28'h84, 28'h83, 28'h82, 28'h81, 28'h80});
    send_ar(6'd3, 32'h0000_0800, 8'd7, 3'd4, 2'd1, hs1);
    s_axi_arvalid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (cyc >= hs1 + 5) break;
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    chk("mid_rvalid_before_rst", 160'(s_axi_rvalid), 160'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_arready", 160'(s_axi_arready), 160'(0));
    chk("mid_rst_ram_ren", 160'(ram_ren), 160'(0));
    chk("mid_rst_ram_addr", 160'(ram_addr), 160'(0));
    chk("mid_rst_rvalid", 160'(s_axi_rvalid), 160'(0));
    chk("mid_rst_rlast", 160'(s_axi_rlast), 160'(0));
    chk("mid_rst_rresp", 160'(s_axi_rresp), 160'(0));
    chk("mid_rst_rid", 160'(s_axi_rid), 160'(0));
    chk("mid_rst_rdata", 160'(s_axi_rdata), 160'(0));
    chk("mid_rst_state", 160'(dbg_state), 160'(0));
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arready_after_mid_release", 160'(s_axi_arready), 160'(1));
    run_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
